io_fifo_responder: RTL and testbench
====================================

IO_FIFO_RESPONDER -- requirements
Module: io_fifo_responder

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning entries per FIFO (power of two, 2..16).
REQ-002 SHALL have port clk, input, 1: single system clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1: reset, asynchronous and active-low.
REQ-004 SHALL have port addr, input, 32: bus address; only addr[3:2] decoded.
REQ-005 SHALL have port cs, input, 1: bus select; an access occurs in every cycle with cs=1.
REQ-006 SHALL have port wr_rd, input, 1: 1 = write, 0 = read.
REQ-007 SHALL have port data_bus_write, input, 32: write data.
REQ-008 SHALL have port data_bus_read, output, 32: read data, combinational from current state.
REQ-009 SHALL have ports tx_data (output, 32), tx_valid (output, 1) and tx_ready (input, 1): TX stream to the device.
REQ-010 SHALL have ports rx_data (input, 32), rx_valid (input, 1) and rx_ready (output, 1): RX stream from the device.
REQ-011 SHALL have port irq, output, 1: registered interrupt request.

Function
REQ-012 Register map by addr[3:2]: 0 TX_DATA (W), 1 RX_DATA (R), 2 STATUS (R), 3 CTRL (R/W).
REQ-013 Write TX_DATA while the TX FIFO is not full: the word is pushed at the closing clock edge.
REQ-014 Write TX_DATA while the TX FIFO is full: the word is dropped, tx_ovf is set and stays set, even if a TX pop happens in the same cycle.
REQ-015 Read RX_DATA while the RX FIFO is not empty: data_bus_read = RX head and the head is popped at the closing edge.
REQ-016 Read RX_DATA while the RX FIFO is empty: data_bus_read = 0 and rx_unf is set and stays set.
REQ-017 STATUS SHALL read as: bit0 tx_full, bit1 tx_empty, bit2 rx_full, bit3 rx_empty, bit4 tx_ovf, bit5 rx_unf, bits[12:8] tx_count, bits[20:16] rx_count, all other bits 0.
REQ-018 CTRL write bit0=1 SHALL flush both FIFOs, bit1 SHALL be stored as irq_en, and bit2=1 SHALL clear tx_ovf and rx_unf; bits 0 and 2 self-clear, so CTRL reads back {30'b0, irq_en, 1'b0}.
REQ-019 Reads of TX_DATA and writes of RX_DATA or STATUS SHALL have no effect; data_bus_read SHALL be 0 whenever cs=0 or wr_rd=1.
REQ-020 tx_valid = !tx_empty; tx_data = TX head; a TX pop occurs when tx_valid and tx_ready are both high.
REQ-021 rx_ready = !rx_full; an RX push occurs when rx_valid and rx_ready are both high.
REQ-022 A simultaneous push and pop on the same FIFO SHALL leave its count unchanged and keep data order.
REQ-023 An RX push into an empty FIFO in the same cycle as an RX_DATA read SHALL be stored, and the read still follows REQ-016.
REQ-024 A flush SHALL win over any push or pop in the same cycle; data pushed in that cycle is discarded.
REQ-025 Pointers SHALL wrap modulo DEPTH, and counts SHALL span 0..DEPTH inclusive.
REQ-026 irq SHALL be registered as irq_en & (!rx_empty | tx_ovf | rx_unf), one cycle after the condition.
REQ-027 Accesses in back-to-back cycles SHALL each take effect, with no wait states.

Reset
REQ-028 rst low SHALL immediately empty both FIFOs and clear tx_ovf, rx_unf, irq_en and irq.
REQ-029 While rst is low: tx_valid=0, rx_ready=0, irq=0 and data_bus_read=0; FIFO storage contents are don't-care.
REQ-030 Reset asserted mid-access SHALL abort that access with no push or pop.

Structure
REQ-031 Register offsets, STATUS/CTRL bit positions and the default DEPTH SHALL live in a shared package io_fifo_pkg.
REQ-032 One sub-module sync_fifo (push, pop, flush, data, full, empty, count) SHALL be instantiated twice, for TX and RX.

Verification
REQ-033 Write 0x11, 0x22, 0x33, 0x44 to TX_DATA with tx_ready=0 -> STATUS = 0x00000409 (tx_full=1, rx_empty=1, tx_count=4).
REQ-034 Then write 0x55, then set tx_ready=1 for 4 cycles -> tx_data sequence 0x11, 0x22, 0x33, 0x44, tx_ovf=1, and STATUS = 0x0000001A.
REQ-035 Device pushes 0xA5 and CTRL=0x2 -> irq=1 the next cycle; read RX_DATA returns 0xA5 and irq falls one cycle after the pop.
REQ-036 Read RX_DATA on an empty FIFO while the device pushes 0x77 -> read returns 0, rx_unf=1, rx_count=1; a second read returns 0x77.
REQ-037 Fill RX, then write CTRL=0x5 in the same cycle as a device push -> rx_count=0, flags cleared, rx_ready=1 the next cycle.
REQ-038 Drive rst low during a TX_DATA write with the FIFO at count 2 -> tx_valid=0 immediately, and tx_count=0 after release.

Source files
------------

// File: rtl/io_fifo_pkg.sv
// Shared register map, STATUS/CTRL bit positions and status packing for the
// bus-to-stream FIFO responder.
package io_fifo_pkg;
  localparam int DEPTH_DEF = 4;

  localparam logic [1:0] REG_TX_DATA = 2'd0;
  localparam logic [1:0] REG_RX_DATA = 2'd1;
  localparam logic [1:0] REG_STATUS  = 2'd2;
  localparam logic [1:0] REG_CTRL    = 2'd3;

  localparam int ST_TX_FULL  = 0;
  localparam int ST_TX_EMPTY = 1;
  localparam int ST_RX_FULL  = 2;
  localparam int ST_RX_EMPTY = 3;
  localparam int ST_TX_OVF   = 4;
  localparam int ST_RX_UNF   = 5;
  localparam int ST_TX_CNT   = 8;
  localparam int ST_RX_CNT   = 16;

  localparam int CTRL_FLUSH  = 0;
  localparam int CTRL_IRQ_EN = 1;
  localparam int CTRL_CLR    = 2;

  typedef struct packed {
    logic       full;
    logic       empty;
    logic [4:0] count;
  } fifo_stat_t;

  function automatic logic [31:0] pack_status(fifo_stat_t tx, fifo_stat_t rx,
                                              logic ovf, logic unf);
    logic [31:0] s;
    s = '0;
    s[ST_TX_FULL]       = tx.full;
    s[ST_TX_EMPTY]      = tx.empty;
    s[ST_RX_FULL]       = rx.full;
    s[ST_RX_EMPTY]      = rx.empty;
    s[ST_TX_OVF]        = ovf;
    s[ST_RX_UNF]        = unf;
    s[ST_TX_CNT +: 5]   = tx.count;
    s[ST_RX_CNT +: 5]   = rx.count;
    return s;
  endfunction
endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with flush; push when full and pop when empty are ignored.
module sync_fifo #(
  parameter  int DEPTH = 4,
  parameter  int W     = 32,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  input  logic [W-1:0]  wdata,
  output logic [W-1:0]  rdata,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);
  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          do_push, do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rdata   = mem[rd_ptr];

  // Power-of-two depth lets the pointers wrap naturally.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= wdata;
  end
endmodule

// File: rtl/io_fifo_responder.sv
// Memory-mapped responder bridging a 32-bit register bus to TX/RX streams
// through two FIFOs, with sticky error flags and a registered interrupt.
module io_fifo_responder
  import io_fifo_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addr,
  input  logic        cs,
  input  logic        wr_rd,
  input  logic [31:0] data_bus_write,
  output logic [31:0] data_bus_read,
  output logic [31:0] tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [31:0] rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic        irq
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [1:0]    sel;
  logic          tx_wr, rx_rd, ctrl_wr, flush;
  logic          tx_full, tx_empty, rx_full, rx_empty;
  logic [CW-1:0] tx_count, rx_count;
  logic [31:0]   rx_head;
  logic          tx_ovf, rx_unf, irq_en;
  fifo_stat_t    tx_st, rx_st;
  logic          unused_addr;

  assign sel         = addr[3:2];
  assign unused_addr = ^{addr[31:4], addr[1:0]};

  assign tx_wr   = cs &  wr_rd & (sel == REG_TX_DATA);
  assign rx_rd   = cs & ~wr_rd & (sel == REG_RX_DATA);
  assign ctrl_wr = cs &  wr_rd & (sel == REG_CTRL);
  assign flush   = ctrl_wr & data_bus_write[CTRL_FLUSH];

  assign tx_valid = ~tx_empty;
  // Held low in reset even though the cleared FIFO would report not-full.
  assign rx_ready = rst & ~rx_full;

  sync_fifo #(.DEPTH(DEPTH), .W(32)) u_tx_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (tx_wr),
    .pop   (tx_valid & tx_ready),
    .flush (flush),
    .wdata (data_bus_write),
    .rdata (tx_data),
    .full  (tx_full),
    .empty (tx_empty),
    .count (tx_count)
  );

  sync_fifo #(.DEPTH(DEPTH), .W(32)) u_rx_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (rx_valid & rx_ready),
    .pop   (rx_rd),
    .flush (flush),
    .wdata (rx_data),
    .rdata (rx_head),
    .full  (rx_full),
    .empty (rx_empty),
    .count (rx_count)
  );

  // Error flags sample full/empty before any same-cycle stream traffic.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_ovf <= 1'b0;
      rx_unf <= 1'b0;
      irq_en <= 1'b0;
      irq    <= 1'b0;
    end else begin
      irq <= irq_en & (~rx_empty | tx_ovf | rx_unf);
      if (ctrl_wr) begin
        irq_en <= data_bus_write[CTRL_IRQ_EN];
        if (data_bus_write[CTRL_CLR]) begin
          tx_ovf <= 1'b0;
          rx_unf <= 1'b0;
        end
      end
      if (tx_wr && tx_full)  tx_ovf <= 1'b1;
      if (rx_rd && rx_empty) rx_unf <= 1'b1;
    end
  end

  assign tx_st = '{full: tx_full, empty: tx_empty, count: 5'(tx_count)};
  assign rx_st = '{full: rx_full, empty: rx_empty, count: 5'(rx_count)};

  always_comb begin
    data_bus_read = '0;
    if (rst && cs && !wr_rd) begin
      case (sel)
        REG_RX_DATA: data_bus_read = rx_empty ? '0 : rx_head;
        REG_STATUS:  data_bus_read = pack_status(tx_st, rx_st, tx_ovf, rx_unf);
        REG_CTRL:    data_bus_read = {30'b0, irq_en, 1'b0};
        default:     data_bus_read = '0;
      endcase
    end
  end
endmodule

// File: tb/tb_io_fifo_responder.sv
// Scoreboard bench for io_fifo_responder: queue models of both FIFOs plus flag
// models; stream traffic is modelled and checked on the falling clock edge.
module tb_io_fifo_responder;
  localparam int DEPTH = 4;
  localparam logic [31:0] A_TX = 32'h0, A_RX = 32'h4, A_ST = 32'h8, A_CTRL = 32'hC;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] addr, data_bus_write, data_bus_read;
  logic        cs, wr_rd;
  logic [31:0] tx_data, rx_data;
  logic        tx_valid, tx_ready, rx_valid, rx_ready, irq;

  always #5 clk = ~clk;

  io_fifo_responder #(.DEPTH(DEPTH)) dut (
    .clk            (clk),
    .rst            (rst),
    .addr           (addr),
    .cs             (cs),
    .wr_rd          (wr_rd),
    .data_bus_write (data_bus_write),
    .data_bus_read  (data_bus_read),
    .tx_data        (tx_data),
    .tx_valid       (tx_valid),
    .tx_ready       (tx_ready),
    .rx_data        (rx_data),
    .rx_valid       (rx_valid),
    .rx_ready       (rx_ready),
    .irq            (irq)
  );

  int          n_chk = 0, n_fail = 0;
  logic [31:0] tx_q[$], rx_q[$];
  logic        m_ovf, m_unf, m_irq_en;
  logic [31:0] g;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, want);
    end
  endtask

  function automatic logic [31:0] exp_status();
    logic [31:0] s;
    s = '0;
    s[0]     = (tx_q.size() == DEPTH);
    s[1]     = (tx_q.size() == 0);
    s[2]     = (rx_q.size() == DEPTH);
    s[3]     = (rx_q.size() == 0);
    s[4]     = m_ovf;
    s[5]     = m_unf;
    s[12:8]  = 5'(tx_q.size());
    s[20:16] = 5'(rx_q.size());
    return s;
  endfunction

  // Stream side: state seen here is the registered state before the next edge.
  always @(negedge clk) begin
    if (rst) begin
      chk("tx_valid", 32'(tx_valid), 32'(tx_q.size() != 0));
      chk("rx_ready", 32'(rx_ready), 32'(rx_q.size() < DEPTH));
      if (tx_ready && tx_q.size() != 0) chk("tx_data", tx_data, tx_q.pop_front());
      if (rx_valid && rx_q.size() < DEPTH) rx_q.push_back(rx_data);
    end
  end

  task automatic cycle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic bus_wr(input logic [31:0] a, input logic [31:0] d);
    bit acc;
    cs = 1'b1; wr_rd = 1'b1; addr = a; data_bus_write = d;
    acc = (tx_q.size() < DEPTH);
    @(posedge clk); #1;
    cs = 1'b0; wr_rd = 1'b0;
    if (a[3:2] == 2'd0) begin
      if (acc) tx_q.push_back(d); else m_ovf = 1'b1;
    end
    if (a[3:2] == 2'd3) begin
      m_irq_en = d[1];
      if (d[2]) begin m_ovf = 1'b0; m_unf = 1'b0; end
      if (d[0]) begin tx_q.delete(); rx_q.delete(); end
    end
  endtask

  task automatic bus_rd(input logic [31:0] a, input string tag, output logic [31:0] got);
    logic [31:0] want;
    bit          pop;
    pop = 1'b0;
    cs = 1'b1; wr_rd = 1'b0; addr = a;
    #1;
    case (a[3:2])
      2'd1:    begin pop = (rx_q.size() != 0); want = pop ? rx_q[0] : 32'h0; end
      2'd2:    want = exp_status();
      2'd3:    want = {30'b0, m_irq_en, 1'b0};
      default: want = 32'h0;
    endcase
    got = data_bus_read;
    chk(tag, got, want);
    @(posedge clk); #1;
    cs = 1'b0;
    if (a[3:2] == 2'd1) begin
      if (pop) void'(rx_q.pop_front()); else m_unf = 1'b1;
    end
  endtask

  initial begin
    rst = 1'b0; cs = 1'b0; wr_rd = 1'b0; addr = '0; data_bus_write = '0;
    tx_ready = 1'b0; rx_valid = 1'b0; rx_data = '0;
    m_ovf = 1'b0; m_unf = 1'b0; m_irq_en = 1'b0;
    cycle(2);
    cs = 1'b1; addr = A_ST; rx_valid = 1'b1;
    #1;
    chk("rst_dbr", data_bus_read, 32'h0);
    chk("rst_txv", 32'(tx_valid), 32'h0);
    chk("rst_rxr", 32'(rx_ready), 32'h0);
    chk("rst_irq", 32'(irq), 32'h0);
    cs = 1'b0; rx_valid = 1'b0; rst = 1'b1;
    cycle(1);
    bus_rd(A_ST, "st_reset", g);
    chk("st_reset_lit", g, 32'h0000000A);

    // Fill TX with the stream stalled, then overflow it and drain.
    for (int i = 1; i <= 4; i++) bus_wr(A_TX, 32'(i * 'h11));
    bus_rd(A_ST, "st_txfull", g);
    chk("st_txfull_lit", g, 32'h00000409);
    bus_wr(A_TX, 32'h55);
    tx_ready = 1'b1;
    cycle(4);
    tx_ready = 1'b0;
    bus_rd(A_ST, "st_ovf", g);
    chk("st_ovf_lit", g, 32'h0000001A);
    bus_wr(A_CTRL, 32'h4);
    bus_rd(A_ST, "st_clr", g);

    // Interrupt from RX data; falls one cycle after the pop.
    rx_valid = 1'b1; rx_data = 32'hA5;
    bus_wr(A_CTRL, 32'h2);
    rx_valid = 1'b0;
    cycle(1);
    chk("irq_on", 32'(irq), 32'h1);
    bus_rd(A_RX, "rx_a5", g);
    chk("rx_a5_lit", g, 32'hA5);
    chk("irq_hold", 32'(irq), 32'h1);
    cycle(1);
    chk("irq_off", 32'(irq), 32'h0);
    bus_rd(A_CTRL, "ctrl_rb", g);

    // Underflow read while the device pushes in the same cycle.
    rx_valid = 1'b1; rx_data = 32'h77;
    bus_rd(A_RX, "rx_unf_rd", g);
    rx_valid = 1'b0;
    chk("rx_unf_lit", g, 32'h0);
    bus_rd(A_ST, "st_unf", g);
    chk("st_unf_lit", g, 32'h00010022);
    chk("irq_unf", 32'(irq), 32'h1);
    bus_rd(A_RX, "rx_77", g);
    chk("rx_77_lit", g, 32'h77);

    // Writes to STATUS and reads of TX_DATA do nothing.
    bus_wr(A_ST, 32'hFFFF_FFFF);
    bus_rd(A_ST, "st_ro", g);
    bus_rd(A_TX, "tx_rd0", g);

    // Back-to-back TX writes with a draining stream: push and pop together.
    tx_ready = 1'b1;
    for (int i = 0; i < 6; i++) bus_wr(A_TX, 32'h100 + 32'(i));
    cycle(2);
    tx_ready = 1'b0;
    bus_rd(A_ST, "st_b2b", g);

    // Fill RX past full, pop one, then flush+clear during a device push.
    rx_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin rx_data = 32'h200 + 32'(i); cycle(1); end
    bus_rd(A_ST, "st_rxfull", g);
    bus_rd(A_RX, "rx_200", g);
    rx_data = 32'h205;
    bus_wr(A_CTRL, 32'h5);
    rx_valid = 1'b0;
    chk("rxr_flush", 32'(rx_ready), 32'h1);
    bus_rd(A_ST, "st_flush", g);
    chk("st_flush_lit", g, 32'h0000000A);

    // Reset in the middle of a TX write with two words queued.
    bus_wr(A_TX, 32'hA1);
    bus_wr(A_TX, 32'hA2);
    cs = 1'b1; wr_rd = 1'b1; addr = A_TX; data_bus_write = 32'hA3;
    #2;
    rst = 1'b0;
    #1;
    chk("txv_rst", 32'(tx_valid), 32'h0);
    tx_q.delete(); rx_q.delete();
    m_ovf = 1'b0; m_unf = 1'b0; m_irq_en = 1'b0;
    cs = 1'b0; wr_rd = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    cycle(1);
    bus_rd(A_ST, "st_after_rst", g);
    chk("st_after_rst_lit", g, 32'h0000000A);
    addr = A_ST;
    #1;
    chk("cs0_dbr", data_bus_read, 32'h0);
    chk("irq_after_rst", 32'(irq), 32'h0);
    cycle(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
